// File: rtl/key_event_queue.sv
// key_event_queue
//   Purpose : turns keyboard decoder updates for four mapped keys into
//             timestamped press/release events held in an 8-entry FIFO.
//   Ports   : clk, rst (async, active high)
//             key_valid/last_change/key_down : decoder update strobe,
//                                              changed code, key state vector
//             evt_valid/evt_ready            : head event handshake
//             evt_lane/evt_press/evt_time    : head event payload
//             lane_held                      : per-lane held state
//             count                          : occupancy 0..8
//             overflow/clr_ovf               : sticky drop flag and its clear
//   Latency : an event is visible one cycle after its key_valid cycle (no bypass).
//   Backpressure: queue absorbs up to 8 events; further events are dropped
//             and flagged, unless a pop happens in the same cycle.

module key_event_queue #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter logic [8:0]  LANE0_CODE = 9'h023,
  parameter logic [8:0]  LANE1_CODE = 9'h02B,
  parameter logic [8:0]  LANE2_CODE = 9'h03B,
  parameter logic [8:0]  LANE3_CODE = 9'h042
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         evt_ready,
  input  logic         clr_ovf,
  output logic         evt_valid,
  output logic [1:0]   evt_lane,
  output logic         evt_press,
  output logic [15:0]  evt_time,
  output logic [3:0]   lane_held,
  output logic [3:0]   count,
  output logic         overflow
);

  // Prescaler width; a divide-by-1 still needs a one-bit register.
  localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef struct packed {
    logic [1:0]  lane;
    logic        press;
    logic [15:0] stamp;
  } evt_t;

  // ---------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------
  logic [PW-1:0] r_prescale;
  logic [15:0]   r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
      r_tick     <= 16'd0;
    end else if (r_prescale == PS_LAST) begin
      r_prescale <= '0;
      r_tick     <= r_tick + 16'd1;   // natural 16-bit wrap FFFF -> 0
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Lane match and event formation
  // ---------------------------------------------------------------------
  logic       w_match;
  logic [1:0] w_lane;
  logic       w_press;
  logic       w_form;
  logic [3:0] r_held;

  // Priority order only matters if two lane codes are configured equal.
  always_comb begin
    w_match = 1'b0;
    w_lane  = 2'd0;
    if (last_change == LANE0_CODE) begin
      w_match = 1'b1;
      w_lane  = 2'd0;
    end else if (last_change == LANE1_CODE) begin
      w_match = 1'b1;
      w_lane  = 2'd1;
    end else if (last_change == LANE2_CODE) begin
      w_match = 1'b1;
      w_lane  = 2'd2;
    end else if (last_change == LANE3_CODE) begin
      w_match = 1'b1;
      w_lane  = 2'd3;
    end
  end

  assign w_press = key_down[last_change];

  // An event is real only when it changes the held state: a press on a held
  // lane is typematic repeat, a release on an idle lane is noise.
  assign w_form = key_valid && w_match && (w_press != r_held[w_lane]);

  // ---------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------
  logic [2:0] r_rd;
  logic [2:0] r_wr;
  logic [3:0] r_count;
  logic       r_ovf;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  assign w_full = (r_count == 4'd8);
  assign w_pop  = (r_count != 4'd0) && evt_ready;
  // A same-cycle pop frees the slot, so a full queue still accepts.
  assign w_push = w_form && (!w_full || w_pop);
  assign w_drop = w_form && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= 3'd0;
      r_wr    <= 3'd0;
      r_count <= 4'd0;
      r_held  <= 4'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 3'd1;
      if (w_pop)  r_rd <= r_rd + 3'd1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase

      // Held state follows the key even when the event itself is dropped.
      if (w_form) r_held[w_lane] <= w_press;

      // A drop in the same cycle as a clear wins.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Event storage: payload is meaningless until written, so no reset.
  // ---------------------------------------------------------------------
  evt_t r_mem [8];
  evt_t w_new;
  evt_t w_head;

  assign w_new = '{lane: w_lane, press: w_press, stamp: r_tick};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_new;
  end

  assign w_head = r_mem[r_rd];

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign evt_valid = (r_count != 4'd0);
  assign evt_lane  = w_head.lane;
  assign evt_press = w_head.press;
  assign evt_time  = w_head.stamp;
  assign lane_held = r_held;
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_key_event_queue.sv
`timescale 1ns/1ps
module tb_key_event_queue;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         evt_ready;
  logic         clr_ovf;
  logic         evt_valid;
  logic [1:0]   evt_lane;
  logic         evt_press;
  logic [15:0]  evt_time;
  logic [3:0]   lane_held;
  logic [3:0]   count;
  logic         overflow;

  int n_vec;
  int n_bad;

  localparam logic [8:0] C0 = 9'h023;
  localparam logic [8:0] C1 = 9'h02B;
  localparam logic [8:0] C2 = 9'h03B;
  localparam logic [8:0] C3 = 9'h042;

  key_event_queue #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
    .evt_valid(evt_valid), .evt_lane(evt_lane), .evt_press(evt_press),
    .evt_time(evt_time), .lane_held(lane_held), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; leaves us 1 ns after the edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle decoder update; on return the outputs show the next cycle.
  task automatic send_key(input logic [8:0] code, input logic down);
    key_down[code] = down;
    last_change    = code;
    key_valid      = 1'b1;
    tick();
    key_valid      = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    n_vec++; if (lane_held !== 4'b0000) begin n_bad++; $display("FAIL reset_held got %b want 0000", lane_held); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_first_press();
    do_reset();
    repeat (20) tick();          // 20 edges at TICK_DIV=4 -> tick counter 5
    send_key(C0, 1'b1);
    n_vec++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", evt_valid); end
    n_vec++; if (evt_lane !== 2'd0) begin n_bad++; $display("FAIL first_lane got %0d want 0", evt_lane); end
    n_vec++; if (evt_press !== 1'b1) begin n_bad++; $display("FAIL first_press got %b want 1", evt_press); end
    n_vec++; if (evt_time !== 16'd5) begin n_bad++; $display("FAIL first_time got %0d want 5", evt_time); end
    n_vec++; if (lane_held !== 4'b0001) begin n_bad++; $display("FAIL first_held got %b want 0001", lane_held); end
    repeat (6) tick();           // head must hold while not accepted
    n_vec++; if (evt_time !== 16'd5 || evt_valid !== 1'b1) begin n_bad++; $display("FAIL first_hold time %0d valid %b want 5 1", evt_time, evt_valid); end
    pop_one();
    n_vec++; if (count !== 4'd0) begin n_bad++; $display("FAIL first_pop count %0d want 0", count); end
  endtask

  task automatic test_typematic();
    do_reset();
    send_key(C0, 1'b1);
    repeat (3) send_key(C0, 1'b1);
    send_key(C0, 1'b0);
    n_vec++; if (count !== 4'd2) begin n_bad++; $display("FAIL typ_count got %0d want 2", count); end
    n_vec++; if (lane_held !== 4'b0000) begin n_bad++; $display("FAIL typ_held got %b want 0000", lane_held); end
    n_vec++; if (evt_press !== 1'b1) begin n_bad++; $display("FAIL typ_first got %b want 1", evt_press); end
    pop_one();
    n_vec++; if (evt_press !== 1'b0 || evt_lane !== 2'd0) begin n_bad++; $display("FAIL typ_second press %b lane %0d want 0 0", evt_press, evt_lane); end
    pop_one();
    n_vec++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL typ_drain got %b want 0", evt_valid); end
  endtask

  task automatic test_unmapped();
    send_key(9'h11C, 1'b1);
    send_key(9'h123, 1'b1);
    n_vec++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_bad++; $display("FAIL unmapped count %0d valid %b want 0 0", count, evt_valid); end
    n_vec++; if (lane_held !== 4'b0000) begin n_bad++; $display("FAIL unmapped_held got %b want 0000", lane_held); end
  endtask

  task automatic test_overflow();
    logic [8:0] codes [4];
    int exp_lane [8];
    int exp_press [8];
    codes     = '{C0, C1, C2, C3};
    exp_lane  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_press = '{1, 1, 1, 1, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) send_key(codes[i], 1'b1);
    for (int i = 0; i < 4; i++) send_key(codes[i], 1'b0);
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full_noflag got %b want 0", overflow); end
    send_key(C0, 1'b1);          // ninth event: dropped
    n_vec++; if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count got %0d want 8", count); end
    n_vec++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_vec++; if (lane_held !== 4'b0001) begin n_bad++; $display("FAIL ovf_held got %b want 0001", lane_held); end
    // Drop coincident with clear: the drop wins.
    clr_ovf = 1'b1;
    send_key(C0, 1'b0);
    clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_prio got %b want 1", overflow); end
    n_vec++; if (lane_held !== 4'b0000) begin n_bad++; $display("FAIL ovf_held2 got %b want 0000", lane_held); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (evt_valid !== 1'b1 || evt_lane !== 2'(exp_lane[i]) || evt_press !== 1'(exp_press[i])) begin
        n_bad++;
        $display("FAIL ovf_order[%0d] valid %b lane %0d press %b want 1 %0d %0d", i, evt_valid, evt_lane, evt_press, exp_lane[i], exp_press[i]);
      end
      pop_one();
    end
    n_vec++; if (evt_valid !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL ovf_ninth_absent valid %b count %0d want 0 0", evt_valid, count); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] codes [4];
    int exp_lane [8];
    int exp_press [8];
    codes     = '{C0, C1, C2, C3};
    exp_lane  = '{1, 2, 3, 0, 1, 2, 3, 2};
    exp_press = '{1, 1, 1, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) send_key(codes[i], 1'b1);
    for (int i = 0; i < 4; i++) send_key(codes[i], 1'b0);
    evt_ready = 1'b1;
    send_key(C2, 1'b1);
    evt_ready = 1'b0;
    n_vec++; if (count !== 4'd8) begin n_bad++; $display("FAIL fpp_count got %0d want 8", count); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    n_vec++; if (lane_held !== 4'b0100) begin n_bad++; $display("FAIL fpp_held got %b want 0100", lane_held); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (evt_valid !== 1'b1 || evt_lane !== 2'(exp_lane[i]) || evt_press !== 1'(exp_press[i])) begin
        n_bad++;
        $display("FAIL fpp_order[%0d] valid %b lane %0d press %b want 1 %0d %0d", i, evt_valid, evt_lane, evt_press, exp_lane[i], exp_press[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_count1_push_pop();
    send_key(C0, 1'b1);
    n_vec++; if (count !== 4'd1) begin n_bad++; $display("FAIL c1_count got %0d want 1", count); end
    evt_ready = 1'b1;
    send_key(C0, 1'b0);
    evt_ready = 1'b0;
    n_vec++; if (count !== 4'd1) begin n_bad++; $display("FAIL c1_pp_count got %0d want 1", count); end
    n_vec++; if (evt_lane !== 2'd0 || evt_press !== 1'b0) begin n_bad++; $display("FAIL c1_head lane %0d press %b want 0 0", evt_lane, evt_press); end
    pop_one();
  endtask

  task automatic test_ready_empty();
    evt_ready = 1'b1;
    tick();
    tick();
    evt_ready = 1'b0;
    n_vec++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_bad++; $display("FAIL rdy_empty count %0d valid %b want 0 0", count, evt_valid); end
    send_key(C3, 1'b1);
    n_vec++; if (count !== 4'd1 || evt_lane !== 2'd3 || evt_press !== 1'b1) begin n_bad++; $display("FAIL rdy_after count %0d lane %0d press %b want 1 3 1", count, evt_lane, evt_press); end
    pop_one();
  endtask

  task automatic test_reset_midop();
    do_reset();
    key_down = '0;
    send_key(C1, 1'b1);
    send_key(C3, 1'b1);
    send_key(C0, 1'b1);
    send_key(C0, 1'b0);
    send_key(C2, 1'b1);
    send_key(C2, 1'b0);
    pop_one();
    n_vec++; if (count !== 4'd5 || lane_held !== 4'b1010) begin n_bad++; $display("FAIL mid_pre count %0d held %b want 5 1010", count, lane_held); end
    rst = 1'b1;
    #2;
    n_vec++; if (count !== 4'd0 || evt_valid !== 1'b0 || lane_held !== 4'b0000) begin n_bad++; $display("FAIL mid_rst count %0d valid %b held %b want 0 0 0000", count, evt_valid, lane_held); end
    tick();
    rst = 1'b0;
    send_key(C1, 1'b0);          // release of a lane held across reset
    n_vec++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_bad++; $display("FAIL mid_release count %0d valid %b want 0 0", count, evt_valid); end
    send_key(C2, 1'b1);          // second edge after reset: tick counter still 0
    n_vec++; if (evt_valid !== 1'b1 || evt_time !== 16'd0 || evt_lane !== 2'd2) begin n_bad++; $display("FAIL mid_tick valid %b time %0d lane %0d want 1 0 2", evt_valid, evt_time, evt_lane); end
    pop_one();
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    key_valid   = 1'b0;
    last_change = 9'd0;
    key_down    = '0;
    evt_ready   = 1'b0;
    clr_ovf     = 1'b0;
    test_reset();
    test_first_press();
    test_typematic();
    test_unmapped();
    test_overflow();
    test_full_push_pop();
    test_count1_push_pop();
    test_ready_empty();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
